// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch key/command path.
// Defaults assume CLOCK_50: 20 ms debounce and a 1 s long-press for clear.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HELD,
      LONG
   } key1_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int LONG_CYCLES_DEF     = 50_000_000;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counter debouncer for one active-low pushbutton.
// Latency: stable follows a clean input change DEBOUNCE_CYCLES+2 edges after first sample.
// No backpressure: free-running, output is a level.
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic core_clk,
   input  logic arst_n,
   input  logic key_raw,
   output logic stable
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync_q;
   logic [CW-1:0] cnt;

   // Levels stay in raw polarity (1 = released) so reset matches an idle button.
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_meta <= 1'b1;
         sync_q    <= 1'b1;
         stable    <= 1'b1;
         cnt       <= '0;
      end else begin
         sync_meta <= key_raw;
         sync_q    <= sync_meta;
         if (sync_q == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync_q;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_command_decoder.sv
// Turns KEY[1:0] into start/stop, lap (short KEY1) and clear (long KEY1) strobes.
// Latency: start_stop_pulse DEBOUNCE_CYCLES+2 edges after press; clear LONG_CYCLES after HELD entry.
// No backpressure: single-cycle strobes, the consumer must sample every cycle.
module key_command_decoder
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [1:0] KEY,
   output logic       start_stop_pulse,
   output logic       lap_pulse,
   output logic       clear_pulse,
   output logic [1:0] key_state
);

   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);

   logic [1:0]  stable;
   logic        pressed0;
   logic        pressed1;
   logic        key0_prev;
   key1_state_t state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic        lap_d;
   logic        clear_d;

   for (genvar k = 0; k < 2; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .core_clk(CLOCK_50),
         .arst_n  (RESET_N),
         .key_raw (KEY[k]),
         .stable  (stable[k])
      );
   end

   assign key_state = ~stable;
   assign pressed0  = key_state[0];
   assign pressed1  = key_state[1];

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      lap_d   = 1'b0;
      clear_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pressed1) begin
               state_d = HELD;
               hcnt_d  = '0;
            end
         end
         HELD: begin
            if (!pressed1) begin
               lap_d   = 1'b1;
               state_d = IDLE;
            end else if (hcnt_q == HCNT_LAST) begin
               clear_d = 1'b1;
               state_d = LONG;
            end else if (hcnt_q != HCNT_MAX) begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         LONG: begin
            // Release after a long press is silent: clear already fired.
            if (!pressed1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q          <= IDLE;
         hcnt_q           <= '0;
         key0_prev        <= 1'b0;
         start_stop_pulse <= 1'b0;
         lap_pulse        <= 1'b0;
         clear_pulse      <= 1'b0;
      end else begin
         state_q          <= state_d;
         hcnt_q           <= hcnt_d;
         key0_prev        <= pressed0;
         start_stop_pulse <= pressed0 & ~key0_prev;
         lap_pulse        <= lap_d;
         clear_pulse      <= clear_d;
      end
   end

endmodule

// File: tb/tb_key_command_decoder.sv
// Scoreboard bench: a window-based key model predicts strobe cycles, a monitor checks them.
module tb_key_command_decoder;

   localparam int D = 4;
   localparam int L = 20;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N  = 1'b0;
   logic [1:0] KEY      = 2'b11;
   logic       start_stop_pulse;
   logic       lap_pulse;
   logic       clear_pulse;
   logic [1:0] key_state;

   key_command_decoder #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .RESET_N         (RESET_N),
      .KEY             (KEY),
      .start_stop_pulse(start_stop_pulse),
      .lap_pulse       (lap_pulse),
      .clear_pulse     (clear_pulse),
      .key_state       (key_state)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int         cyc;
      logic [2:0] bits;   // {clear, lap, start}
   } ev_t;

   ev_t        evq[$];
   logic [1:0] hist[$];   // hist[i] = KEY sampled i edges ago
   logic [1:0] stable_m;  // modelled debounced level, 1 = released
   int         edge_idx;
   bit         clr_pend;
   int         clr_due;

   int n_checks = 0;
   int n_fail   = 0;
   int last_start = -1, last_lap = -1, last_clear = -1;
   int n_start = 0, n_lap = 0, n_clear = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add_ev(input int c, input logic [2:0] b);
      ev_t t;
      if (evq.size() > 0 && evq[evq.size()-1].cyc == c) begin
         t = evq[evq.size()-1];
         t.bits = t.bits | b;
         evq[evq.size()-1] = t;
      end else begin
         t.cyc  = c;
         t.bits = b;
         evq.push_back(t);
      end
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_front(2'b11);
      stable_m = 2'b11;
      clr_pend = 1'b0;
      clr_due  = 0;
      edge_idx = 0;
      evq.delete();
   endfunction

   // A key's level flips once its last D synchronized samples all disagree with it.
   function automatic void model_edge();
      logic [1:0] prev;
      logic [1:0] h;
      bit all_dis;
      int n;
      n = edge_idx;
      hist.push_front(KEY);
      if (hist.size() > D + 2) void'(hist.pop_back());
      prev = stable_m;
      if (clr_pend && clr_due == n && prev[1] == 1'b0) begin
         add_ev(n, 3'b100);
         clr_pend = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         all_dis = 1'b1;
         for (int i = 2; i <= D + 1; i++) begin
            h = hist[i];
            if (h[k] == prev[k]) all_dis = 1'b0;
         end
         if (all_dis) stable_m[k] = ~prev[k];
      end
      if (prev[0] && !stable_m[0]) add_ev(n + 1, 3'b001);
      if (prev[1] && !stable_m[1]) begin
         clr_pend = 1'b1;
         clr_due  = n + 1 + L;
      end
      if (!prev[1] && stable_m[1] && clr_pend) begin
         add_ev(n + 1, 3'b010);
         clr_pend = 1'b0;
      end
      edge_idx = n + 1;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge CLOCK_50);
         if (!RESET_N) model_reset();
         else model_edge();
      end
   end

   // Monitor: compares strobes whenever the DUT or the scoreboard has one due.
   initial begin
      logic [2:0] act, exp;
      logic [1:0] exp_ks;
      int         le;
      forever begin
         @(negedge CLOCK_50);
         act = {clear_pulse, lap_pulse, start_stop_pulse};
         if (!RESET_N) begin
            evq.delete();
            check("reset_pulses", int'(act), 0);
            check("reset_key_state", int'(key_state), 0);
         end else begin
            le  = edge_idx - 1;
            exp = 3'b000;
            if (evq.size() > 0 && evq[0].cyc == le) begin
               exp = evq[0].bits;
               void'(evq.pop_front());
            end
            if (exp != 3'b000 || act != 3'b000) check("pulses", int'(act), int'(exp));
            exp_ks = ~stable_m;
            check("key_state", int'(key_state), int'(exp_ks));
            if (act[0]) begin last_start = le; n_start++; end
            if (act[1]) begin last_lap   = le; n_lap++;   end
            if (act[2]) begin last_clear = le; n_clear++; end
         end
      end
   end

   task automatic drive(input logic [1:0] k, input int n);
      KEY = k;
      repeat (n) @(posedge CLOCK_50);
      #2;
   endtask

   task automatic do_reset(input int n);
      RESET_N = 1'b0;
      repeat (n) @(posedge CLOCK_50);
      #2;
      RESET_N = 1'b1;
   endtask

   function automatic int pick_len();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) return $urandom_range(1, 3);
      if (r < 8) return $urandom_range(4, 12);
      return $urandom_range(20, 40);
   endfunction

   initial begin
      int p, s_start, s_lap, s_clear, cd0, cd1;
      logic [1:0] k;

      // Reset with both keys held, then release reset with them still held.
      @(posedge CLOCK_50);
      #2;
      KEY = 2'b00;
      do_reset(10);
      drive(2'b00, 30);
      check("s1_start_edge", last_start, 6);
      check("s1_clear_edge", last_clear, 26);
      drive(2'b11, 20);

      // KEY0 bounce then clean hold.
      s_start = n_start;
      for (int i = 0; i < 6; i++) drive({1'b1, i[0]}, 2);
      p = edge_idx;
      drive(2'b10, 30);
      drive(2'b11, 20);
      check("s2_start_count", n_start - s_start, 1);
      check("s2_start_edge", last_start, p + 6);

      // KEY1 short press.
      s_clear = n_clear;
      s_lap   = n_lap;
      p = edge_idx;
      drive(2'b01, 10);
      drive(2'b11, 20);
      check("s3_lap_edge", last_lap, p + 16);
      check("s3_lap_count", n_lap - s_lap, 1);
      check("s3_no_clear", n_clear - s_clear, 0);

      // KEY1 long press.
      s_lap   = n_lap;
      s_clear = n_clear;
      p = edge_idx;
      drive(2'b01, 60);
      drive(2'b11, 20);
      check("s4_clear_edge", last_clear, p + 26);
      check("s4_clear_count", n_clear - s_clear, 1);
      check("s4_no_lap", n_lap - s_lap, 0);

      // Simultaneous press, KEY1 released first.
      s_clear = n_clear;
      p = edge_idx;
      drive(2'b00, 8);
      drive(2'b10, 22);
      drive(2'b11, 20);
      check("s5_start_edge", last_start, p + 6);
      check("s5_lap_edge", last_lap, p + 14);
      check("s5_no_clear", n_clear - s_clear, 0);

      // Reset while KEY1 is HELD with hcnt=10, key kept held through reset.
      s_lap = n_lap;
      drive(2'b01, 17);
      do_reset(3);
      drive(2'b01, 40);
      drive(2'b11, 20);
      check("s6_clear_edge", last_clear, 26);
      check("s6_no_lap", n_lap - s_lap, 0);

      // Random independent key activity with one reset in the middle.
      k = 2'b11;
      cd0 = 0;
      cd1 = 0;
      for (int c = 0; c < 2000; c++) begin
         if (cd0 == 0) begin k[0] = ~k[0]; cd0 = pick_len(); end else cd0--;
         if (cd1 == 0) begin k[1] = ~k[1]; cd1 = pick_len(); end else cd1--;
         if (c == 1000) do_reset(3);
         drive(k, 1);
      end
      drive(2'b11, 60);
      check("queue_drained", evq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
